tb_sim_ctrl: RTL and testbench

Memory-mapped simulation control and console device for the CHERIoT testbench. It snoops the core data bus for writes to a block of console registers and buffers characters per channel in line FIFOs. Completed lines are drained one character per cycle through a single round-robin-arbitrated output stream. It also detects end-of-test writes, reports pass/fail exit codes and runs a no-retire watchdog, so one block replaces ad-hoc console and finish logic.

---
 rtl/tb_sim_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tb_sim_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tb_sim_ctrl.sv
// tb_sim_ctrl: console line FIFOs with round-robin line output, end-of-test and no-retire watchdog.
// Optional `TB_SIM_CTRL_ECHO_EN` echoes output characters and the final verdict to the simulator console.
module tb_sim_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h8380_0200,
  parameter int          NUM_CH         = 2,
  parameter int          LINE_DEPTH     = 64,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       data_req_i,
  input  logic                                       data_gnt_i,
  input  logic                                       data_we_i,
  input  logic [3:0]                                 data_be_i,
  input  logic [31:0]                                data_addr_i,
  input  logic [31:0]                                data_wdata_i,
  input  logic                                       retire_i,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] out_ch_o,
  output logic [7:0]                                 out_char_o,
  output logic                                       out_eol_o,
  output logic [NUM_CH-1:0]                          overflow_o,
  output logic                                       end_o,
  output logic                                       pass_o,
  output logic [6:0]                                 exit_code_o,
  output logic                                       timeout_o,
  output logic                                       done_o
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(LINE_DEPTH);
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_lock, r_end, r_pass, r_to;
  logic [CW-1:0]     r_ch, r_rr, w_sel, w_rr_next;
  logic [6:0]        r_code;
  logic [WW-1:0]     r_wd;
  logic [NUM_CH-1:0] w_hit, w_elig, w_nz, w_one;
  logic [8:0]        w_head [NUM_CH];
  logic [8:0]        w_hd;
  logic              w_run, w_drain, w_wr, w_end, w_to, w_nl, w_pop, w_found, w_empty;
  logic              w_unused;

  assign w_unused  = ^{data_wdata_i[31:8], data_be_i[3:1]};
  assign w_run     = r_state == S_RUN;
  assign w_drain   = r_state == S_DRAIN;
  assign w_wr      = data_req_i & data_gnt_i & data_we_i & data_be_i[0];
  assign w_end     = w_run & w_hit[0] & data_wdata_i[7];
  assign w_to      = (TIMEOUT_CYCLES != 0) && w_run && !retire_i && r_wd == WD_LAST;
  assign w_nl      = data_wdata_i[7:0] == 8'h0A;
  assign w_pop     = r_lock & out_ready_i;
  assign w_hd      = w_head[r_ch];
  assign w_empty   = ~|w_nz;
  assign w_rr_next = (r_ch == CW'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;

  assign out_valid_o = r_lock;
  assign out_ch_o    = r_lock ? r_ch : '0;
  assign out_char_o  = r_lock ? w_hd[7:0] : 8'h00;
  assign out_eol_o   = r_lock & (w_hd[8] | (w_drain & w_one[r_ch]));
  assign end_o       = r_end;
  assign pass_o      = r_pass;
  assign exit_code_o = r_code;
  assign timeout_o   = r_to;
  assign done_o      = r_state == S_DONE;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [8:0]    r_mem [LINE_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, r_lp;
    logic          r_ovf, w_popc, w_req, w_full, w_push, w_eolin;
    assign w_hit[c]    = w_wr && data_addr_i == BASE_ADDR + 32'(4 * c);
    assign w_popc      = w_pop && r_ch == CW'(c);
    assign w_full      = r_cnt == (AW+1)'(LINE_DEPTH);
    assign w_req       = w_run & w_hit[c] & ((c != 0) | ~data_wdata_i[7]);
    assign w_push      = w_req & (~w_full | w_popc);
    assign w_eolin     = w_nl | (r_cnt == (AW+1)'(LINE_DEPTH - 1));
    assign w_nz[c]     = r_cnt != '0;
    assign w_one[c]    = r_cnt == (AW+1)'(1);
    // A line completing this cycle is already eligible so the output starts next cycle
    assign w_elig[c]   = w_drain ? w_nz[c] : w_run & ((r_lp != '0) | (w_push & w_eolin));
    assign w_head[c]   = r_mem[r_rp];
    assign overflow_o[c] = r_ovf;
    always_ff @(posedge clk_i)
      if (w_push) r_mem[r_wp] <= {w_eolin, data_wdata_i[7:0]};
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_lp  <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_popc) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_popc);
        r_lp  <= r_lp + (AW+1)'(w_push & w_eolin) - (AW+1)'(w_popc & w_head[c][8]);
        if (w_req & w_full & ~w_popc) r_ovf <= 1'b1;
      end
    end
  end

  // Lowest eligible channel overall, overridden by the lowest one at or after rr
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (w_elig[c]) begin
        w_found = 1'b1;
        w_sel   = CW'(c);
      end
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (w_elig[c] && CW'(c) >= r_rr) w_sel = CW'(c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
      r_lock  <= 1'b0;
      r_ch    <= '0;
      r_rr    <= '0;
      r_end   <= 1'b0;
      r_pass  <= 1'b0;
      r_to    <= 1'b0;
      r_code  <= '0;
      r_wd    <= '0;
    end else begin
      if (!r_lock) begin
        r_lock <= w_found;
        r_ch   <= w_found ? w_sel : r_ch;
      end else if (w_pop && out_eol_o) begin
        r_lock <= 1'b0;
        r_rr   <= w_rr_next;
      end
      if (w_run) r_wd <= retire_i ? '0 : r_wd + 1'b1;
      if (w_end || w_to) begin
        r_state <= S_DRAIN;
        r_end   <= 1'b1;
        r_code  <= w_end ? data_wdata_i[6:0] : 7'h7F;
        r_pass  <= w_end && data_wdata_i[6:0] == 7'h00;
        r_to    <= !w_end;
      end else if (w_drain && w_empty && !r_lock) begin
        r_state <= S_DONE;
      end
    end
  end

`ifdef TB_SIM_CTRL_ECHO_EN
  logic r_sol;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sol <= 1'b1;
    end else begin
      if (w_pop) begin
        if (r_sol) $write("[ch%0d] ", out_ch_o);
        $write("%c", out_char_o);
        r_sol <= out_eol_o;
      end
      if (w_drain && w_empty && !r_lock)
        $display("SIM END: %s code=%0d timeout=%0b", r_pass ? "PASS" : "FAIL", r_code, r_to);
    end
  end
`else
`endif
endmodule

// File: tb/tb_tb_sim_ctrl.sv
// tb_tb_sim_ctrl: scoreboard bench for tb_sim_ctrl; expected characters are queued, a negedge monitor checks handshakes.
module tb_tb_sim_ctrl;
  localparam logic [31:0] BASE = 32'h8380_0200;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, gnt = 1'b0, we = 1'b0, retire = 1'b1, ready = 1'b1;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic        out_valid, out_ch, out_eol, end_s, pass_s, timeout_s, done_s;
  logic [7:0]  out_char;
  logic [1:0]  overflow;
  logic [6:0]  exit_code;

  int n_tests = 0, n_fail = 0;
  logic [9:0] q[$];

  tb_sim_ctrl #(.BASE_ADDR(BASE), .NUM_CH(2), .LINE_DEPTH(64), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_i(gnt), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .retire_i(retire),
    .out_valid_o(out_valid), .out_ready_i(ready), .out_ch_o(out_ch), .out_char_o(out_char),
    .out_eol_o(out_eol), .overflow_o(overflow), .end_o(end_s), .pass_o(pass_s),
    .exit_code_o(exit_code), .timeout_o(timeout_s), .done_o(done_s)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted character must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out got ch%0d char=%h eol=%0b, want no output", out_ch, out_char, out_eol);
      end else begin
        logic [9:0] e;
        e = q.pop_front();
        if ({out_ch, out_char, out_eol} !== e) begin
          n_fail++;
          $display("FAIL out_char got ch%0d char=%h eol=%0b, want ch%0d char=%h eol=%0b",
                   out_ch, out_char, out_eol, e[9], e[8:1], e[0]);
        end
      end
    end
  end

  function automatic logic [9:0] ex(input logic ch, input logic [7:0] c, input logic e);
    return {ch, c, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic wr_raw(input logic [31:0] a, input logic [3:0] b, input logic [7:0] d);
    req = 1'b1; gnt = 1'b1; we = 1'b1; be = b; addr = a; wdata = {24'h0, d};
    tick();
    req = 1'b0; gnt = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    wr_raw(BASE + 32'(4 * ch), 4'hF, d);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk(nm, q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [23:0] all_outs();
    return {out_valid, out_ch, out_char, out_eol, overflow, end_s, pass_s, exit_code, timeout_s, done_s};
  endfunction

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs", all_outs(), 0);

    // Line on ch0, plus writes that must be ignored
    wr_raw(BASE + 32'd8, 4'hF, 8'h0A);
    wr_raw(BASE, 4'hE, 8'h0A);
    wr_raw(BASE + 32'd1, 4'hF, 8'h0A);
    tick();
    chk("ignored_writes", out_valid, 0);
    q.push_back(ex(0, "h", 0));
    q.push_back(ex(0, "i", 0));
    q.push_back(ex(0, 8'h0A, 1));
    wr(0, "h");
    wr(0, "i");
    chk("t1_no_valid_before_nl", out_valid, 0);
    wr(0, 8'h0A);
    chk("t1_valid_latency", out_valid, 1);
    chk("t1_first_char", {out_ch, out_char, out_eol}, {1'b0, 8'h68, 1'b0});
    wait_drain("t1_drain");

    // Round robin: ch0 locked, ch1 and another ch0 line waiting
    ready = 1'b0;
    q.push_back(ex(0, "a", 0));
    q.push_back(ex(0, 8'h0A, 1));
    q.push_back(ex(1, "b", 0));
    q.push_back(ex(1, 8'h0A, 1));
    q.push_back(ex(0, "c", 0));
    q.push_back(ex(0, 8'h0A, 1));
    wr(0, "a");
    wr(0, 8'h0A);
    wr(1, "b");
    wr(1, 8'h0A);
    wr(0, "c");
    wr(0, 8'h0A);
    tick();
    chk("t2_held_stable", {out_valid, out_ch, out_char}, {1'b1, 1'b0, 8'h61});
    ready = 1'b1;
    wait_drain("t2_drain");

    // Overflow with forced line break on ch1
    ready = 1'b0;
    for (int i = 0; i < 64; i++) q.push_back(ex(1, 8'(8'h20 + i), i == 63));
    for (int i = 0; i < 69; i++) begin
      wr(1, 8'(8'h20 + i));
      if (i == 62) chk("t3_no_valid_at_63", out_valid, 0);
      if (i == 63) begin
        chk("t3_forced_eol_valid", {out_valid, out_ch, out_char}, {1'b1, 1'b1, 8'h20});
        chk("t3_no_overflow_yet", overflow, 2'b00);
      end
    end
    chk("t3_overflow", overflow, 2'b10);
    ready = 1'b1;
    wait_drain("t3_drain");

    // End of test with a partial line to drain
    q.push_back(ex(0, "a", 0));
    q.push_back(ex(0, "b", 1));
    wr(0, "a");
    wr(0, "b");
    wr(0, 8'h80);
    chk("t4_end", {end_s, pass_s, exit_code, timeout_s, done_s}, {1'b1, 1'b1, 7'h00, 1'b0, 1'b0});
    wait_drain("t4_drain");
    begin
      int n = 0;
      while (!done_s && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t4_done", done_s, 1);
    wr(1, "z");
    wr(1, 8'h0A);
    tick();
    chk("t4_writes_ignored_done", {out_valid, done_s}, {1'b0, 1'b1});

    // Watchdog
    do_reset();
    retire = 1'b0;
    for (int k = 0; k < 6; k++) begin
      repeat (49) tick();
      retire = 1'b1;
      tick();
      retire = 1'b0;
    end
    chk("t5_no_timeout_with_retire", {timeout_s, end_s}, 0);
    repeat (99) tick();
    chk("t5_not_yet_at_99", timeout_s, 0);
    tick();
    chk("t5_timeout_at_100", {timeout_s, end_s, pass_s, exit_code}, {1'b1, 1'b1, 1'b0, 7'h7F});
    tick();
    chk("t5_done_after_timeout", done_s, 1);

    // Reset mid-line
    do_reset();
    retire = 1'b1;
    ready = 1'b0;
    wr(0, "x");
    wr(0, "y");
    wr(0, 8'h0A);
    chk("t6_valid_before_reset", out_valid, 1);
    do_reset();
    chk("t6_reset_outputs", all_outs(), 0);
    ready = 1'b1;
    q.push_back(ex(0, "x", 0));
    q.push_back(ex(0, 8'h0A, 1));
    wr(0, "x");
    wr(0, 8'h0A);
    chk("t6_first_after_reset", {out_valid, out_char}, {1'b1, 8'h78});
    wait_drain("t6_drain");
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit");
  end
endmodule
